sevenseg_scan_driver: RTL



---
 rtl/sevenseg_scan_driver.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: multiplexes two 0..99 values onto a 4-digit
// common-anode 7-segment display as "LL.RR", converting binary to BCD by
// repeated subtraction once per scan frame.
// Ports: clk, rst_n (async, active-low); left_val/right_val [7:0] binary
// inputs; blank forces anodes off; an[3:0] anodes (an[3] leftmost),
// seg[6:0] {g..a} and dp, all active-low and registered.
// Option: SEVENSEG_LEADING_ZERO_BLANK_EN darkens a zero left tens digit.
module sevenseg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] left_val,
  input  logic [7:0] right_val,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_CONV  = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] DARK = 7'b1111111;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = DARK;
    endcase
    return s;
  endfunction

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    didx_q, didx_d;
  logic          tick, fstart;

  logic [1:0] st_q, st_d;
  logic       pend_q, pend_d;
  logic [7:0] smp_l_q, smp_l_d, smp_r_q, smp_r_d;
  logic [7:0] rem_l_q, rem_l_d, rem_r_q, rem_r_d;
  logic [3:0] ten_l_q, ten_l_d, ten_r_q, ten_r_d;
  logic       ok_l_q, ok_l_d, ok_r_q, ok_r_d;
  logic       sub_l, sub_r;

  // Conversion result waits in buf_* until the next frame start so a
  // frame never mixes digits of two samples.
  logic [3:0] buf_lt_q, buf_lt_d, buf_lu_q, buf_lu_d;
  logic [3:0] buf_rt_q, buf_rt_d, buf_ru_q, buf_ru_d;
  logic       buf_lok_q, buf_lok_d, buf_rok_q, buf_rok_d;

  logic [3:0] act_lt_q, act_lt_d, act_lu_q, act_lu_d;
  logic [3:0] act_rt_q, act_rt_d, act_ru_q, act_ru_d;
  logic       act_lok_q, act_lok_d, act_rok_q, act_rok_d;

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] dig;
  logic       dok;

  always_comb begin
    tick   = (pcnt_q == PMAX);
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    didx_d = tick ? didx_q - 2'd1 : didx_q;
    fstart = tick && (didx_q == 2'd0);
  end

  always_comb begin
    st_d     = st_q;
    pend_d   = pend_q;
    smp_l_d  = smp_l_q;
    smp_r_d  = smp_r_q;
    rem_l_d  = rem_l_q;
    rem_r_d  = rem_r_q;
    ten_l_d  = ten_l_q;
    ten_r_d  = ten_r_q;
    ok_l_d   = ok_l_q;
    ok_r_d   = ok_r_q;
    buf_lt_d = buf_lt_q;
    buf_lu_d = buf_lu_q;
    buf_rt_d = buf_rt_q;
    buf_ru_d = buf_ru_q;
    buf_lok_d = buf_lok_q;
    buf_rok_d = buf_rok_q;
    // Out-of-range samples skip subtraction so conversion stays bounded.
    sub_l = ok_l_q && (rem_l_q >= 8'd10);
    sub_r = ok_r_q && (rem_r_q >= 8'd10);
    unique case (st_q)
      S_IDLE: begin
        if (fstart || pend_q) begin
          smp_l_d = left_val;
          smp_r_d = right_val;
          pend_d  = 1'b0;
          st_d    = S_LATCH;
        end
      end
      S_LATCH: begin
        rem_l_d = smp_l_q;
        rem_r_d = smp_r_q;
        ten_l_d = 4'd0;
        ten_r_d = 4'd0;
        ok_l_d  = (smp_l_q <= 8'd99);
        ok_r_d  = (smp_r_q <= 8'd99);
        st_d    = S_CONV;
      end
      S_CONV: begin
        if (sub_l) begin
          rem_l_d = rem_l_q - 8'd10;
          ten_l_d = ten_l_q + 4'd1;
        end
        if (sub_r) begin
          rem_r_d = rem_r_q - 8'd10;
          ten_r_d = ten_r_q + 4'd1;
        end
        if (!sub_l && !sub_r) st_d = S_LOAD;
      end
      S_LOAD: begin
        buf_lt_d  = ten_l_q;
        buf_lu_d  = rem_l_q[3:0];
        buf_rt_d  = ten_r_q;
        buf_ru_d  = rem_r_q[3:0];
        buf_lok_d = ok_l_q;
        buf_rok_d = ok_r_q;
        st_d      = S_IDLE;
      end
    endcase
  end

  always_comb begin
    act_lt_d  = fstart ? buf_lt_q  : act_lt_q;
    act_lu_d  = fstart ? buf_lu_q  : act_lu_q;
    act_rt_d  = fstart ? buf_rt_q  : act_rt_q;
    act_ru_d  = fstart ? buf_ru_q  : act_ru_q;
    act_lok_d = fstart ? buf_lok_q : act_lok_q;
    act_rok_d = fstart ? buf_rok_q : act_rok_q;
  end

  // Outputs are built from next-state index and digits so all three
  // change on the same edge as didx.
  always_comb begin
    dig = act_ru_d;
    dok = act_rok_d;
    unique case (didx_d)
      2'd3: begin dig = act_lt_d; dok = act_lok_d; end
      2'd2: begin dig = act_lu_d; dok = act_lok_d; end
      2'd1: begin dig = act_rt_d; dok = act_rok_d; end
      2'd0: begin dig = act_ru_d; dok = act_rok_d; end
    endcase
    seg_d = dok ? seg7(dig) : DASH;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    if (didx_d == 2'd3 && dok && dig == 4'd0) seg_d = DARK;
`endif
    an_d = blank ? 4'b1111 : ~(4'b0001 << didx_d);
    dp_d = !((didx_d == 2'd2) && !blank);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q    <= '0;
      didx_q    <= 2'd0;
      st_q      <= S_IDLE;
      pend_q    <= 1'b1;
      smp_l_q   <= 8'd0;
      smp_r_q   <= 8'd0;
      rem_l_q   <= 8'd0;
      rem_r_q   <= 8'd0;
      ten_l_q   <= 4'd0;
      ten_r_q   <= 4'd0;
      ok_l_q    <= 1'b1;
      ok_r_q    <= 1'b1;
      buf_lt_q  <= 4'd0;
      buf_lu_q  <= 4'd0;
      buf_rt_q  <= 4'd0;
      buf_ru_q  <= 4'd0;
      buf_lok_q <= 1'b1;
      buf_rok_q <= 1'b1;
      act_lt_q  <= 4'd0;
      act_lu_q  <= 4'd0;
      act_rt_q  <= 4'd0;
      act_ru_q  <= 4'd0;
      act_lok_q <= 1'b1;
      act_rok_q <= 1'b1;
      an_q      <= 4'b1111;
      seg_q     <= DARK;
      dp_q      <= 1'b1;
    end else begin
      pcnt_q    <= pcnt_d;
      didx_q    <= didx_d;
      st_q      <= st_d;
      pend_q    <= pend_d;
      smp_l_q   <= smp_l_d;
      smp_r_q   <= smp_r_d;
      rem_l_q   <= rem_l_d;
      rem_r_q   <= rem_r_d;
      ten_l_q   <= ten_l_d;
      ten_r_q   <= ten_r_d;
      ok_l_q    <= ok_l_d;
      ok_r_q    <= ok_r_d;
      buf_lt_q  <= buf_lt_d;
      buf_lu_q  <= buf_lu_d;
      buf_rt_q  <= buf_rt_d;
      buf_ru_q  <= buf_ru_d;
      buf_lok_q <= buf_lok_d;
      buf_rok_q <= buf_rok_d;
      act_lt_q  <= act_lt_d;
      act_lu_q  <= act_lu_d;
      act_rt_q  <= act_rt_d;
      act_ru_q  <= act_ru_d;
      act_lok_q <= act_lok_d;
      act_rok_q <= act_rok_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
